// File: rtl/io_port_buffered.sv
// Buffered CPU I/O port: an input FIFO filled by an external device and popped by
// the datapath, plus an output FIFO pushed by the datapath and drained externally.
module io_port_buffered #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_rd,
    output logic [DATA_W-1:0] in_rdata,
    output logic [AW:0]       in_count,

    input  logic              out_wr,
    input  logic [DATA_W-1:0] out_wdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW:0]       out_count,

    output logic              in_unf,
    output logic              out_ovf,
    input  logic              clr_flags
);

    localparam logic [AW-1:0] PTR_INC   = AW'(1);
    localparam logic [AW:0]   CNT_INC   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_EMPTY = '0;

    // ------------------------------------------------------------------
    // Input FIFO state
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] in_mem [DEPTH];
    logic [AW-1:0]     in_wptr_reg;
    logic [AW-1:0]     in_rptr_reg;
    logic [AW:0]       in_count_reg;
    logic [DATA_W-1:0] in_rdata_reg;
    logic              in_unf_reg;

    logic              in_full;
    logic              in_empty;
    logic              in_push;
    logic              in_pop;
    logic              in_unf_set;

    // ------------------------------------------------------------------
    // Output FIFO state
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] out_mem [DEPTH];
    logic [AW-1:0]     out_wptr_reg;
    logic [AW-1:0]     out_rptr_reg;
    logic [AW:0]       out_count_reg;
    logic              out_ovf_reg;

    logic              out_full;
    logic              out_empty;
    logic              out_push;
    logic              out_pop;
    logic              out_ovf_set;

    // Handshake decode depends only on registered occupancy, so neither in_rd
    // nor out_ready can reach in_ready/out_valid combinationally.
    always_comb begin
        in_full     = (in_count_reg == CNT_FULL);
        in_empty    = (in_count_reg == CNT_EMPTY);
        in_push     = in_valid && !in_full && !reset;
        in_pop      = in_rd && !in_empty && !reset;
        in_unf_set  = in_rd && in_empty;

        out_full    = (out_count_reg == CNT_FULL);
        out_empty   = (out_count_reg == CNT_EMPTY);
        out_pop     = !out_empty && out_ready && !reset;
        // A full FIFO still accepts a word when its head leaves in the same cycle.
        out_push    = out_wr && (!out_full || out_pop) && !reset;
        out_ovf_set = out_wr && out_full && !out_pop;
    end

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (in_push) begin
            in_mem[in_wptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_wptr_reg  <= '0;
            in_rptr_reg  <= '0;
            in_count_reg <= '0;
            in_rdata_reg <= '0;
        end else begin
            if (in_push) begin
                in_wptr_reg <= in_wptr_reg + PTR_INC;
            end
            // Read data only changes on a real pop; an underflow read keeps the old word.
            if (in_pop) begin
                in_rdata_reg <= in_mem[in_rptr_reg];
                in_rptr_reg  <= in_rptr_reg + PTR_INC;
            end
            case ({in_push, in_pop})
                2'b10:   in_count_reg <= in_count_reg + CNT_INC;
                2'b01:   in_count_reg <= in_count_reg - CNT_INC;
                default: in_count_reg <= in_count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (out_push) begin
            out_mem[out_wptr_reg] <= out_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_wptr_reg  <= '0;
            out_rptr_reg  <= '0;
            out_count_reg <= '0;
        end else begin
            if (out_push) begin
                out_wptr_reg <= out_wptr_reg + PTR_INC;
            end
            if (out_pop) begin
                out_rptr_reg <= out_rptr_reg + PTR_INC;
            end
            case ({out_push, out_pop})
                2'b10:   out_count_reg <= out_count_reg + CNT_INC;
                2'b01:   out_count_reg <= out_count_reg - CNT_INC;
                default: out_count_reg <= out_count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a new event wins over a simultaneous clear
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            in_unf_reg  <= 1'b0;
            out_ovf_reg <= 1'b0;
        end else begin
            if (in_unf_set) begin
                in_unf_reg <= 1'b1;
            end else if (clr_flags) begin
                in_unf_reg <= 1'b0;
            end
            if (out_ovf_set) begin
                out_ovf_reg <= 1'b1;
            end else if (clr_flags) begin
                out_ovf_reg <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = !in_full;
    assign in_rdata  = in_rdata_reg;
    assign in_count  = in_count_reg;
    assign in_unf    = in_unf_reg;

    assign out_valid = !out_empty;
    // Storage is never reset, so the head is masked while empty to keep the bus defined.
    assign out_data  = out_empty ? '0 : out_mem[out_rptr_reg];
    assign out_count = out_count_reg;
    assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_io_port_buffered.sv
// Scoreboard bench for io_port_buffered: stimulus queues expected words, two
// monitors pop and compare whenever the DUT hands a word out.
module tb_io_port_buffered;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int AW     = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_rd = 1'b0;
    logic [DATA_W-1:0] in_rdata;
    logic [AW:0]       in_count;
    logic              out_wr = 1'b0;
    logic [DATA_W-1:0] out_wdata = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [AW:0]       out_count;
    logic              in_unf;
    logic              out_ovf;
    logic              clr_flags = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] in_exp_q[$];
    logic [DATA_W-1:0] out_exp_q[$];

    io_port_buffered #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rd     (in_rd),
        .in_rdata  (in_rdata),
        .in_count  (in_count),
        .out_wr    (out_wr),
        .out_wdata (out_wdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .in_unf    (in_unf),
        .out_ovf   (out_ovf),
        .clr_flags (clr_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Input monitor: a word requested at one edge is compared after the next one.
    initial begin
        logic              pend;
        logic [DATA_W-1:0] exp;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (in_exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL in_rdata: got 0x%0h, expected no read", in_rdata);
                end else begin
                    exp = in_exp_q.pop_front();
                    $display("in  read : got 0x%0h exp 0x%0h", in_rdata, exp);
                    check("in_rdata", in_rdata, exp);
                end
            end
            pend = in_rd && !reset;
        end
    end

    // Output monitor: compare the head whenever the consumer takes it.
    initial begin
        logic [DATA_W-1:0] exp;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (out_exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_data: got 0x%0h, expected no word", out_data);
                end else begin
                    exp = out_exp_q.pop_front();
                    $display("out take : got 0x%0h exp 0x%0h", out_data, exp);
                    check("out_data", out_data, exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_count",  in_count,  0);
        check("rst_out_count", out_count, 0);
        check("rst_in_rdata",  in_rdata,  0);
        check("rst_in_unf",    in_unf,    0);
        check("rst_out_ovf",   out_ovf,   0);

        // Fill input FIFO, fifth word held off while full
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 32'hA1 + k;
            step();
        end
        check("in_full_count", in_count, 4);
        check("in_full_ready", in_ready, 0);
        in_data = 32'hA5;
        step();
        check("in_hold_count", in_count, 4);
        check("in_hold_ready", in_ready, 0);
        // Pop while full: no same-cycle push
        in_rd = 1'b1;
        in_exp_q.push_back(32'hA1);
        step();
        check("in_pop_full_count", in_count, 3);
        check("in_pop_full_ready", in_ready, 1);
        // A5 enters while A2 leaves
        in_exp_q.push_back(32'hA2);
        step();
        check("in_pushpop_count", in_count, 3);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_exp_q.push_back(32'hA3 + k);
            step();
        end
        check("in_drained_count", in_count, 0);
        check("in_no_unf_yet", in_unf, 0);
        // Read on empty: data holds, underflow flag set
        in_exp_q.push_back(32'hA5);
        step();
        in_rd = 1'b0;
        check("in_unf_set", in_unf, 1);
        check("in_unf_count", in_count, 0);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("in_unf_clr", in_unf, 0);
        // Set beats clear in the same cycle
        in_rd = 1'b1;
        clr_flags = 1'b1;
        in_exp_q.push_back(32'hA5);
        step();
        in_rd = 1'b0;
        clr_flags = 1'b0;
        check("in_unf_prio", in_unf, 1);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("in_unf_clr2", in_unf, 0);

        // Output fill, overflow drop, push-while-full-with-pop
        out_ready = 1'b0;
        out_wr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            out_wdata = 32'h10 + k;
            out_exp_q.push_back(32'h10 + k);
            step();
        end
        check("out_full_count", out_count, 4);
        check("out_full_valid", out_valid, 1);
        out_wdata = 32'h14;
        step();
        check("out_ovf_set", out_ovf, 1);
        check("out_ovf_count", out_count, 4);
        out_wdata = 32'h15;
        out_ready = 1'b1;
        out_exp_q.push_back(32'h15);
        step();
        out_wr = 1'b0;
        check("out_swap_count", out_count, 4);
        for (int k = 0; k < 4; k++) step();
        out_ready = 1'b0;
        check("out_drained_count", out_count, 0);
        check("out_drained_valid", out_valid, 0);
        check("out_ovf_sticky", out_ovf, 1);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("out_ovf_clr", out_ovf, 0);

        // Sustained push+pop on both FIFOs across pointer wrap
        in_valid = 1'b1;
        out_wr = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_data = 32'hB0 + k;
            out_wdata = 32'hC0 + k;
            out_exp_q.push_back(32'hC0 + k);
            step();
        end
        in_rd = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3 * DEPTH; k++) begin
            in_data = 32'hB0 + k + 2;
            in_exp_q.push_back(32'hB0 + k);
            out_wdata = 32'hC0 + k + 2;
            out_exp_q.push_back(32'hC0 + k + 2);
            step();
            check("stream_in_count", in_count, 2);
            check("stream_out_count", out_count, 2);
        end
        in_valid = 1'b0;
        out_wr = 1'b0;
        in_exp_q.push_back(32'hB0 + 3 * DEPTH);
        step();
        in_exp_q.push_back(32'hB0 + 3 * DEPTH + 1);
        step();
        in_rd = 1'b0;
        out_ready = 1'b0;
        check("stream_in_empty", in_count, 0);
        check("stream_out_empty", out_count, 0);
        check("stream_in_unf", in_unf, 0);
        check("stream_out_ovf", out_ovf, 0);

        // Reset with both FIFOs half full; handshakes in the reset cycle ignored
        in_valid = 1'b1;
        out_wr = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_data = 32'hD0 + k;
            out_wdata = 32'hE0 + k;
            step();
        end
        check("pre_rst_in_count", in_count, 2);
        check("pre_rst_out_count", out_count, 2);
        reset = 1'b1;
        in_data = 32'hDEAD;
        out_wdata = 32'hBEEF;
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        out_wr = 1'b0;
        check("mid_rst_in_count", in_count, 0);
        check("mid_rst_out_count", out_count, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_in_rdata", in_rdata, 0);

        // Fresh traffic after reset must not see stale entries
        in_valid = 1'b1;
        in_data = 32'hF0;
        step();
        in_valid = 1'b0;
        in_rd = 1'b1;
        in_exp_q.push_back(32'hF0);
        step();
        in_rd = 1'b0;
        check("post_rst_in_count", in_count, 0);
        out_wr = 1'b1;
        out_wdata = 32'hF1;
        step();
        out_wr = 1'b0;
        check("post_rst_out_count", out_count, 1);
        check("post_rst_out_head", out_data, 32'hF1);
        out_ready = 1'b1;
        out_exp_q.push_back(32'hF1);
        step();
        out_ready = 1'b0;
        check("post_rst_out_empty", out_valid, 0);

        step();
        step();
        check("in_queue_drained", in_exp_q.size(), 0);
        check("out_queue_drained", out_exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
